// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming SECDED engine.
// Holds the FSM state enum, decode status codes and codeword layout.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CORR = 2'b01;
  localparam logic [1:0] ST_DERR = 2'b10;

  localparam int CW_BITS   = 16;
  localparam int NUM_DATA  = 11;
  localparam int NUM_CHECK = 4;
  localparam int POS_P0    = 0;

  // Codeword position of data bit d(i+1); check bits sit at the powers of two.
  localparam int DATA_POS [NUM_DATA] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hamming_secded.sv
// Combinational (16,11) SECDED: encode builds a codeword, decode corrects or flags it.
// Zero latency, no flow control; status is ST_OK whenever mode selects encode.
module hamming_secded
  import hamming_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic [1:0]  status
);

  logic [15:0] cw;
  logic [15:0] corr;
  logic [10:0] dd;
  logic [3:0]  syn;
  logic        par;
  logic        parity_all;
  logic [1:0]  st;

  always_comb begin
    cw  = '0;
    par = 1'b0;
    for (int i = 0; i < NUM_DATA; i++) cw[DATA_POS[i]] = in[i];
    // Check bit positions are zero while each parity is summed, so order is irrelevant.
    for (int b = 0; b < NUM_CHECK; b++) begin
      par = 1'b0;
      for (int k = 1; k < CW_BITS; k++) begin
        if (k[b]) par = par ^ cw[k];
      end
      cw[1 << b] = par;
    end
    cw[POS_P0] = ^cw[15:1];
  end

  always_comb begin
    syn = '0;
    for (int b = 0; b < NUM_CHECK; b++) begin
      for (int k = 1; k < CW_BITS; k++) begin
        if (k[b]) syn[b] = syn[b] ^ in[k];
      end
    end
    parity_all = ^in;
    corr = in;
    // A zero syndrome with odd overall parity means p0 itself was hit.
    if (parity_all) corr[syn] = ~corr[syn];
    dd = '0;
    for (int i = 0; i < NUM_DATA; i++) dd[i] = corr[DATA_POS[i]];
    if (parity_all)      st = ST_CORR;
    else if (syn != '0)  st = ST_DERR;
    else                 st = ST_OK;
  end

  always_comb begin
    out    = cw;
    status = ST_OK;
    if (mode) begin
      out    = {st, 3'b000, dd[10:8], dd[7:0]};
      status = st;
    end
  end

endmodule

// File: rtl/hamming_engine.sv
// Batch Hamming encoder/decoder over a byte memory; 5 cycles per message, done after 5*NUM_MSG+1.
// No backpressure: memory is assumed to accept a write and return read data every cycle.
module hamming_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        n_single,
  output logic [7:0]        n_double
);

  state_t      state_q, state_d;
  logic [6:0]  msg_cnt_q, msg_cnt_d;
  logic        mode_q, mode_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] res_q, res_d;
  logic [7:0]  n_single_q, n_single_d;
  logic [7:0]  n_double_q, n_double_d;

  logic [15:0]       sd_out;
  logic [1:0]        sd_status;
  logic [ADDR_W-1:0] msg_off;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] out_addr;
  logic              last_msg;

  hamming_secded u_secded (
    .mode   (mode_q),
    .in     ({mem_rd_data, lo_q}),
    .out    (sd_out),
    .status (sd_status)
  );

  assign msg_off  = ADDR_W'({msg_cnt_q, 1'b0});
  assign in_addr  = ADDR_W'(IN_BASE) + msg_off;
  assign out_addr = ADDR_W'(OUT_BASE) + msg_off;
  assign last_msg = (msg_cnt_q == 7'(NUM_MSG - 1));

  always_comb begin
    state_d     = state_q;
    msg_cnt_d   = msg_cnt_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    res_d       = res_q;
    n_single_d  = n_single_q;
    n_double_d  = n_double_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RD_LO;
          msg_cnt_d  = '0;
          mode_d     = mode;
          n_single_d = 8'h00;
          n_double_d = 8'h00;
        end
      end
      RD_LO: begin
        mem_addr = in_addr;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = in_addr + ADDR_W'(1);
        lo_d     = mem_rd_data;
        state_d  = CAP_HI;
      end
      CAP_HI: begin
        res_d = sd_out;
        if (sd_status == ST_CORR && n_single_q != 8'hFF) n_single_d = n_single_q + 8'd1;
        if (sd_status == ST_DERR && n_double_q != 8'hFF) n_double_d = n_double_q + 8'd1;
        state_d = WR_LO;
      end
      WR_LO: begin
        mem_addr    = out_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = res_q[7:0];
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_addr    = out_addr + ADDR_W'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = res_q[15:8];
        if (last_msg) begin
          state_d = DONE;
        end else begin
          msg_cnt_d = msg_cnt_q + 7'd1;
          state_d   = RD_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      msg_cnt_q  <= '0;
      mode_q     <= 1'b0;
      lo_q       <= 8'h00;
      res_q      <= 16'h0000;
      n_single_q <= 8'h00;
      n_double_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      msg_cnt_q  <= msg_cnt_d;
      mode_q     <= mode_d;
      lo_q       <= lo_d;
      res_q      <= res_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
    end
  end

  assign busy     = (state_q == RD_LO) || (state_q == RD_HI) || (state_q == CAP_HI) ||
                    (state_q == WR_LO) || (state_q == WR_HI);
  assign done     = (state_q == DONE);
  assign n_single = n_single_q;
  assign n_double = n_double_q;

endmodule

// File: tb/tb_hamming_engine.sv
// Directed bench for hamming_engine: one NUM_MSG=1 instance for hand vectors, one default instance for batch/reset cases.
module tb_hamming_engine;

  logic clk = 1'b0;
  logic reset, start0, start1, mode;
  always #5 clk = ~clk;

  logic [7:0] a0, wd0, rd0, ns0, nd0;
  logic [7:0] a1, wd1, rd1, ns1, nd1;
  logic       we0, we1, busy0, busy1, done0, done1;

  hamming_engine u_dut (
    .clk(clk), .reset(reset), .start(start0), .mode(mode),
    .mem_addr(a0), .mem_wr_en(we0), .mem_wr_data(wd0), .mem_rd_data(rd0),
    .busy(busy0), .done(done0), .n_single(ns0), .n_double(nd0)
  );

  hamming_engine #(.NUM_MSG(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode),
    .mem_addr(a1), .mem_wr_en(we1), .mem_wr_data(wd1), .mem_rd_data(rd1),
    .busy(busy1), .done(done1), .n_single(ns1), .n_double(nd1)
  );

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       tb_we, tb_sel, tb_clr;
  logic [7:0] tb_wa, tb_wd;
  int         wr_cnt0;

  always @(posedge clk) begin
    rd0 <= mem0[a0];
    rd1 <= mem1[a1];
    if (tb_clr) wr_cnt0 <= 0;
    else if (we0) wr_cnt0 <= wr_cnt0 + 1;
    if (we0) mem0[a0] <= wd0;
    if (we1) mem1[a1] <= wd1;
    if (tb_we) begin
      if (tb_sel) mem1[tb_wa] <= tb_wd;
      else        mem0[tb_wa] <= tb_wd;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic sel, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    tb_we = 1'b1; tb_sel = sel; tb_wa = addr; tb_wd = data;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic run(input logic sel, input logic md, output int cyc);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    mode = md;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1;
    while (!(sel ? done1 : done0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic p1, p2, p4, p8;
    logic [15:0] cw;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p8 = ^d[10:4];
    cw = {d[10:4], p8, d[3:1], p4, d[0], p2, p1, 1'b0};
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic vec1(input string tag, input logic md, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                      input logic [7:0] exp_ns, input logic [7:0] exp_nd);
    int cyc;
    poke(1'b1, 8'd0, lo);
    poke(1'b1, 8'd1, hi);
    run(1'b1, md, cyc);
    check({tag, "_cyc"}, cyc, 6);
    check({tag, "_lo"}, mem1[30], exp_lo);
    check({tag, "_hi"}, mem1[31], exp_hi);
    check({tag, "_ns"}, ns1, exp_ns);
    check({tag, "_nd"}, nd1, exp_nd);
  endtask

  logic [10:0] data [15];
  logic [15:0] cw_ref;
  int          cyc;
  logic        found;

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 1'b0;
    tb_we = 1'b0; tb_sel = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00; tb_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_we", we0, 0);
    check("rst_addr", a0, 0);
    check("rst_wd", wd0, 0);
    check("rst_ns", ns0, 0);
    reset = 1'b0;

    // Hand-computed single-message vectors.
    vec1("enc01",   1'b0, 8'h01, 8'h00, 8'h0F, 8'h00, 8'd0, 8'd0);
    vec1("encFF",   1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd0);
    vec1("enc555",  1'b0, 8'h55, 8'h05, 8'h5A, 8'hAA, 8'd0, 8'd0);
    vec1("dec0007", 1'b1, 8'h07, 8'h00, 8'h01, 8'h40, 8'd1, 8'd0);
    vec1("dec0005", 1'b1, 8'h05, 8'h00, 8'h00, 8'h80, 8'd0, 8'd1);
    vec1("dec0001", 1'b1, 8'h01, 8'h00, 8'h00, 8'h40, 8'd1, 8'd0);
    vec1("dec0000", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 8'd0);
    vec1("decFFFF", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'd0, 8'd0);
    vec1("decBA5A", 1'b1, 8'h5A, 8'hBA, 8'h55, 8'h45, 8'd1, 8'd0);
    vec1("enc_clr", 1'b0, 8'h01, 8'h00, 8'h0F, 8'h00, 8'd0, 8'd0);

    // Batch encode of random data, then decode with one flipped bit per codeword.
    for (int i = 0; i < 15; i++) begin
      data[i] = 11'($urandom_range(2047, 0));
      poke(1'b0, 8'(2 * i), data[i][7:0]);
      poke(1'b0, 8'(2 * i + 1), {5'($urandom_range(31, 0)), data[i][10:8]});
    end
    run(1'b0, 1'b0, cyc);
    check("enc15_cyc", cyc, 76);
    check("enc15_ns", ns0, 0);
    check("enc15_nd", nd0, 0);
    for (int i = 0; i < 15; i++) begin
      cw_ref = ref_enc(data[i]);
      check("enc15_lo", {24'(i), mem0[30 + 2 * i]}, {24'(i), cw_ref[7:0]});
      check("enc15_hi", {24'(i), mem0[31 + 2 * i]}, {24'(i), cw_ref[15:8]});
    end
    for (int i = 0; i < 15; i++) begin
      cw_ref = {mem0[31 + 2 * i], mem0[30 + 2 * i]} ^ (16'h0001 << $urandom_range(15, 0));
      poke(1'b0, 8'(2 * i), cw_ref[7:0]);
      poke(1'b0, 8'(2 * i + 1), cw_ref[15:8]);
    end
    run(1'b0, 1'b1, cyc);
    check("dec15_cyc", cyc, 76);
    check("dec15_ns", ns0, 15);
    check("dec15_nd", nd0, 0);
    for (int i = 0; i < 15; i++) begin
      check("dec15_lo", {24'(i), mem0[30 + 2 * i]}, {24'(i), data[i][7:0]});
      check("dec15_hi", {24'(i), mem0[31 + 2 * i]}, {24'(i), 2'b01, 3'b000, data[i][10:8]});
    end

    // start and mode toggled mid-run must not disturb the run.
    @(negedge clk);
    start0 = 1'b1; mode = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 7) begin start0 = 1'b1; mode = 1'b1; end
      else start0 = 1'b0;
    end
    start0 = 1'b0;
    check("busy_start_cyc", cyc, 76);
    check("busy_start_ns", ns0, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    start0 = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("rst_start_busy", busy0, 0);
    check("rst_start_done", done0, 0);
    start0 = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_idle", busy0, 0);
    run(1'b0, 1'b0, cyc);
    check("after_rst_cyc", cyc, 76);

    // Reset during WR_LO of message 3 (0-based) abandons the run.
    @(negedge clk);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0; start0 = 1'b1; mode = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (we0 && a0 == 8'd36) found = 1'b1;
      else @(negedge clk);
    end
    check("r042_found", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("r042_busy", busy0, 0);
    check("r042_done", done0, 0);
    check("r042_we", we0, 0);
    check("r042_wrcnt", wr_cnt0, 7);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("r042_wrcnt_late", wr_cnt0, 7);
    check("r042_done_late", done0, 0);
    check("r042_busy_late", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
